// File: rtl/dcache_port_arbiter_if.sv
// ============================================================================
// dcache_port_arbiter_if : request/response port bundle between a requester and the data cache
// Rev 1.0
// ============================================================================
`default_nettype none

interface dcache_port_arbiter_if;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [3:0]  req_be;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_error;
  logic        resp_ready;

  // master issues requests and consumes responses
  modport master (
    output req_valid, req_we, req_addr, req_data, req_be, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_error
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_data, req_be, resp_ready,
    output req_ready, resp_valid, resp_data, resp_error
  );
endinterface

`default_nettype wire

// File: rtl/dcache_port_arbiter.sv
// ============================================================================
// dcache_port_arbiter : shares one single-outstanding dcache port between PTW and LSU
// Rev 1.0
// ============================================================================
`default_nettype none

module dcache_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input wire                    clk,
  input wire                    rst_n,
  input wire                    flush_i,
  dcache_port_arbiter_if.slave  ptw,
  dcache_port_arbiter_if.slave  lsu,
  dcache_port_arbiter_if.master dcache
);

  localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  starve_cnt, starve_nxt;
  logic        drop_flag, drop_nxt;
  logic        owner_lsu, owner_nxt;
  logic [31:0] addr_q, addr_nxt;
  logic [31:0] data_q, data_nxt;
  logic        we_q, we_nxt;
  logic [3:0]  be_q, be_nxt;
  logic        grant_ptw, grant_lsu;
  logic        cache_resp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      starve_cnt <= 3'd0;
      drop_flag  <= 1'b0;
      owner_lsu  <= 1'b0;
      addr_q     <= 32'd0;
      data_q     <= 32'd0;
      we_q       <= 1'b0;
      be_q       <= 4'd0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      drop_flag  <= drop_nxt;
      owner_lsu  <= owner_nxt;
      addr_q     <= addr_nxt;
      data_q     <= data_nxt;
      we_q       <= we_nxt;
      be_q       <= be_nxt;
    end
  end

  always_comb begin
    state_nxt         = state;
    starve_nxt        = starve_cnt;
    drop_nxt          = drop_flag;
    owner_nxt         = owner_lsu;
    addr_nxt          = addr_q;
    data_nxt          = data_q;
    we_nxt            = we_q;
    be_nxt            = be_q;
    grant_ptw         = 1'b0;
    grant_lsu         = 1'b0;
    cache_resp_ready  = 1'b0;
    ptw.req_ready     = 1'b0;
    lsu.req_ready     = 1'b0;
    ptw.resp_valid    = 1'b0;
    ptw.resp_data     = 32'd0;
    ptw.resp_error    = 1'b0;
    lsu.resp_valid    = 1'b0;
    lsu.resp_data     = 32'd0;
    lsu.resp_error    = 1'b0;
    dcache.req_valid  = 1'b0;
    dcache.req_we     = 1'b0;
    dcache.req_addr   = 32'd0;
    dcache.req_data   = 32'd0;
    dcache.req_be     = 4'd0;
    dcache.resp_ready = 1'b0;

    case (state)
      IDLE: begin
        // ready is combinational, so hold it low while reset is asserted
        if (rst_n) begin
          grant_lsu = lsu.req_valid && (!ptw.req_valid || starve_cnt == STARVE_MAX);
          grant_ptw = ptw.req_valid && !grant_lsu;
        end
        ptw.req_ready = grant_ptw;
        lsu.req_ready = grant_lsu;
        if (grant_lsu) begin
          state_nxt  = ISSUE;
          owner_nxt  = 1'b1;
          addr_nxt   = lsu.req_addr;
          data_nxt   = lsu.req_data;
          we_nxt     = lsu.req_we;
          be_nxt     = lsu.req_be;
          starve_nxt = 3'd0;
          drop_nxt   = flush_i;
        end else if (grant_ptw) begin
          state_nxt = ISSUE;
          owner_nxt = 1'b0;
          addr_nxt  = ptw.req_addr;
          data_nxt  = ptw.req_data;
          we_nxt    = ptw.req_we;
          be_nxt    = ptw.req_be;
          if (lsu.req_valid && starve_cnt != STARVE_MAX) begin
            starve_nxt = starve_cnt + 3'd1;
          end
        end
      end

      ISSUE: begin
        dcache.req_valid = 1'b1;
        dcache.req_we    = we_q;
        dcache.req_addr  = addr_q;
        dcache.req_data  = data_q;
        dcache.req_be    = be_q;
        if (flush_i && owner_lsu) begin
          drop_nxt = 1'b1;
        end
        if (dcache.req_ready) begin
          state_nxt = WAIT_RESP;
        end
      end

      WAIT_RESP: begin
        if (owner_lsu) begin
          // a flushed LSU result is swallowed here but still drained from the cache
          lsu.resp_valid   = dcache.resp_valid && !drop_flag;
          lsu.resp_data    = dcache.resp_data;
          lsu.resp_error   = dcache.resp_error;
          cache_resp_ready = drop_flag || lsu.resp_ready;
        end else begin
          ptw.resp_valid   = dcache.resp_valid;
          ptw.resp_data    = dcache.resp_data;
          ptw.resp_error   = dcache.resp_error;
          cache_resp_ready = ptw.resp_ready;
        end
        dcache.resp_ready = cache_resp_ready;
        if (flush_i && owner_lsu) begin
          drop_nxt = 1'b1;
        end
        if (dcache.resp_valid && cache_resp_ready) begin
          state_nxt = IDLE;
          drop_nxt  = 1'b0;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_dcache_port_arbiter.sv
// ============================================================================
// tb_dcache_port_arbiter : directed stimulus with a transaction-level reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_dcache_port_arbiter;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush_i = 1'b0;
  always #5 clk = ~clk;

  dcache_port_arbiter_if ptw_if ();
  dcache_port_arbiter_if lsu_if ();
  dcache_port_arbiter_if dc_if ();

  dcache_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush_i(flush_i),
    .ptw    (ptw_if),
    .lsu    (lsu_if),
    .dcache (dc_if)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // cache responder: stall_cycles of req_ready low, then resp_delay cycles before the response
  int          stall_cycles = 0;
  int          resp_delay   = 0;
  logic [31:0] resp_word    = 32'd0;
  logic        resp_err     = 1'b0;
  logic        req_hs_q     = 1'b0;
  logic        resp_hs_q    = 1'b0;
  int          rphase       = 0;
  int          rcnt         = 0;

  always @(posedge clk) begin
    #2;
    if (!rst_n) begin
      rphase = 0;
      rcnt   = 0;
      dc_if.req_ready  = 1'b0;
      dc_if.resp_valid = 1'b0;
      dc_if.resp_data  = 32'd0;
      dc_if.resp_error = 1'b0;
    end else begin
      if (req_hs_q) begin rphase = 1; rcnt = 0; end
      if (resp_hs_q) begin rphase = 0; rcnt = 0; end
      dc_if.req_ready  = 1'b0;
      dc_if.resp_valid = 1'b0;
      dc_if.resp_data  = 32'd0;
      dc_if.resp_error = 1'b0;
      if (rphase == 0) begin
        if (dc_if.req_valid) begin
          if (rcnt >= stall_cycles) dc_if.req_ready = 1'b1;
          else rcnt++;
        end
      end else begin
        if (rcnt >= resp_delay) begin
          dc_if.resp_valid = 1'b1;
          dc_if.resp_data  = resp_word;
          dc_if.resp_error = resp_err;
        end else begin
          rcnt++;
        end
      end
    end
  end

  // reference model: one transaction record plus the count of PTW wins the LSU sat through
  bit          m_busy = 0, m_sent = 0, m_lsu = 0, m_drop = 0;
  int          m_streak = 0;
  logic [31:0] m_addr = 0, m_data = 0;
  logic        m_we = 0;
  logic [3:0]  m_be = 0;

  always @(negedge clk) begin : compare
    logic g_p, g_l, e_pr, e_lr, e_dv, e_drr, e_pv, e_lv;
    g_p = 0; g_l = 0; e_pr = 0; e_lr = 0; e_dv = 0; e_drr = 0; e_pv = 0; e_lv = 0;
    req_hs_q  = rst_n && dc_if.req_valid && dc_if.req_ready;
    resp_hs_q = rst_n && dc_if.resp_valid && dc_if.resp_ready;

    if (!rst_n) begin
      m_busy = 0; m_sent = 0; m_lsu = 0; m_drop = 0; m_streak = 0;
      chk32("rst_dc_addr", dc_if.req_addr, 32'd0);
      chk32("rst_dc_data", dc_if.req_data, 32'd0);
      chk32("rst_dc_we_be", {27'd0, dc_if.req_we, dc_if.req_be}, 32'd0);
      chk32("rst_ptw_rdata", ptw_if.resp_data, 32'd0);
      chk32("rst_lsu_rdata", lsu_if.resp_data, 32'd0);
    end else if (!m_busy) begin
      g_l = lsu_if.req_valid && (!ptw_if.req_valid || m_streak == LIMIT);
      g_p = ptw_if.req_valid && !g_l;
      e_pr = g_p;
      e_lr = g_l;
    end else if (!m_sent) begin
      e_dv = 1;
    end else if (m_lsu) begin
      e_lv  = dc_if.resp_valid && !m_drop;
      e_drr = m_drop ? 1'b1 : lsu_if.resp_ready;
    end else begin
      e_pv  = dc_if.resp_valid;
      e_drr = ptw_if.resp_ready;
    end

    chk1("ptw_req_ready", ptw_if.req_ready, e_pr);
    chk1("lsu_req_ready", lsu_if.req_ready, e_lr);
    chk1("dc_req_valid", dc_if.req_valid, e_dv);
    chk1("dc_resp_ready", dc_if.resp_ready, e_drr);
    chk1("ptw_resp_valid", ptw_if.resp_valid, e_pv);
    chk1("lsu_resp_valid", lsu_if.resp_valid, e_lv);
    if (e_dv) begin
      chk32("dc_req_addr", dc_if.req_addr, m_addr);
      chk32("dc_req_data", dc_if.req_data, m_data);
      chk32("dc_req_we_be", {27'd0, dc_if.req_we, dc_if.req_be}, {27'd0, m_we, m_be});
    end
    if (e_pv) chk32("ptw_resp", {ptw_if.resp_error, ptw_if.resp_data[30:0]}, {dc_if.resp_error, dc_if.resp_data[30:0]});
    if (e_pv) chk1("ptw_resp_d31", ptw_if.resp_data[31], dc_if.resp_data[31]);
    if (e_lv) chk32("lsu_resp", lsu_if.resp_data, dc_if.resp_data);
    if (e_lv) chk1("lsu_resp_err", lsu_if.resp_error, dc_if.resp_error);

    // advance to the state the next rising edge produces
    if (rst_n) begin
      if (!m_busy) begin
        if (g_p || g_l) begin
          m_busy = 1; m_sent = 0; m_lsu = g_l;
          m_addr = g_l ? lsu_if.req_addr : ptw_if.req_addr;
          m_data = g_l ? lsu_if.req_data : ptw_if.req_data;
          m_we   = g_l ? lsu_if.req_we   : ptw_if.req_we;
          m_be   = g_l ? lsu_if.req_be   : ptw_if.req_be;
          m_drop = g_l && flush_i;
          if (g_l) m_streak = 0;
          else if (lsu_if.req_valid && m_streak < LIMIT) m_streak++;
        end
      end else begin
        if (flush_i && m_lsu) m_drop = 1;
        if (!m_sent) begin
          if (dc_if.req_ready) m_sent = 1;
        end else if (dc_if.resp_valid && e_drr) begin
          m_busy = 0; m_drop = 0;
        end
      end
    end
  end

  task automatic send(input bit to_lsu, input logic [31:0] a, input logic [31:0] d,
                      input logic we, input logic [3:0] be);
    logic got;
    got = 1'b0;
    @(posedge clk); #1;
    if (to_lsu) begin
      lsu_if.req_valid = 1'b1; lsu_if.req_addr = a; lsu_if.req_data = d;
      lsu_if.req_we = we; lsu_if.req_be = be;
    end else begin
      ptw_if.req_valid = 1'b1; ptw_if.req_addr = a; ptw_if.req_data = d;
      ptw_if.req_we = we; ptw_if.req_be = be;
    end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = to_lsu ? lsu_if.req_ready : ptw_if.req_ready;
    end
    chk1("grant_seen", got, 1'b1);
    @(posedge clk); #1;
    lsu_if.req_valid = 1'b0;
    ptw_if.req_valid = 1'b0;
  endtask

  // bit k of seq is 1 when the k-th grant went to the LSU
  task automatic collect_grants(input int n, output logic [15:0] seq);
    int k;
    k = 0;
    seq = 16'd0;
    for (int i = 0; i < 30 * n && k < n; i++) begin
      @(negedge clk);
      if (ptw_if.req_ready && k < 16) begin seq[k] = 1'b0; k++; end
      if (lsu_if.req_ready && k < 16) begin seq[k] = 1'b1; k++; end
    end
    chk32("grant_count", k, n);
  endtask

  task automatic summary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
  endtask

  initial begin : watchdog
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish in time");
    summary();
    $finish;
  end

  initial begin : main
    logic [15:0] seq;
    logic        got;
    int          cnt, hs, lv;

    ptw_if.req_valid = 1'b1; ptw_if.req_we = 1'b0; ptw_if.req_addr = 32'h0000_5000;
    ptw_if.req_data = 32'd0; ptw_if.req_be = 4'hF; ptw_if.resp_ready = 1'b1;
    lsu_if.req_valid = 1'b1; lsu_if.req_we = 1'b0; lsu_if.req_addr = 32'h0000_6000;
    lsu_if.req_data = 32'd0; lsu_if.req_be = 4'hF; lsu_if.resp_ready = 1'b1;

    // reset with both requesters active: nothing may be granted
    repeat (3) @(negedge clk) begin
      chk1("rst_ptw_ready", ptw_if.req_ready, 1'b0);
      chk1("rst_lsu_ready", lsu_if.req_ready, 1'b0);
    end
    @(posedge clk); #1;
    ptw_if.req_valid = 1'b0;
    lsu_if.req_valid = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // LSU load alone
    stall_cycles = 0; resp_delay = 2; resp_word = 32'hDEADBEEF; resp_err = 1'b0;
    send(1'b1, 32'h0000_1000, 32'd0, 1'b0, 4'hF);
    @(negedge clk);
    chk1("t029_req_next_cycle", dc_if.req_valid, 1'b1);
    chk32("t029_addr", dc_if.req_addr, 32'h0000_1000);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = dc_if.resp_valid;
    end
    chk1("t029_resp_seen", got, 1'b1);
    chk32("t029_lsu_data", lsu_if.resp_data, 32'hDEADBEEF);
    chk1("t029_lsu_valid", lsu_if.resp_valid, 1'b1);
    chk1("t029_ptw_valid", ptw_if.resp_valid, 1'b0);
    @(posedge clk); #1;

    // store held through a stalled cache
    stall_cycles = 3; resp_delay = 0; resp_word = 32'd0;
    send(1'b1, 32'h0000_2004, 32'h00AB_0000, 1'b1, 4'b0100);
    cnt = 0; hs = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (dc_if.req_valid) begin
        cnt++;
        chk32("t031_data", dc_if.req_data, 32'h00AB_0000);
        chk32("t031_be", {28'd0, dc_if.req_be}, 32'h0000_0004);
      end
      if (dc_if.req_valid && dc_if.req_ready) hs++;
    end
    chk32("t031_issue_cycles", cnt, 4);
    chk32("t031_handshakes", hs, 1);

    // flush while an LSU load waits; LSU not ready, cache must still drain
    stall_cycles = 0; resp_delay = 3; resp_word = 32'h1234_5678;
    lsu_if.resp_ready = 1'b0;
    send(1'b1, 32'h0000_3000, 32'd0, 1'b0, 4'hF);
    @(posedge clk); #1; flush_i = 1'b1;
    @(posedge clk); #1; flush_i = 1'b0;
    lv = 0; hs = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (lsu_if.resp_valid) lv++;
      if (dc_if.resp_valid && dc_if.resp_ready) hs++;
    end
    chk32("t032_lsu_resp_valid_cycles", lv, 0);
    chk32("t032_cache_resp_handshakes", hs, 1);
    @(posedge clk); #1;
    lsu_if.resp_ready = 1'b1;

    // PTW error response with a slow consumer
    resp_delay = 0; resp_word = 32'hCAFE_0001; resp_err = 1'b1;
    ptw_if.resp_ready = 1'b0;
    send(1'b0, 32'h0000_4000, 32'd0, 1'b0, 4'hF);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = ptw_if.resp_valid;
    end
    chk1("t033_resp_seen", got, 1'b1);
    chk1("t033_dc_rr_low1", dc_if.resp_ready, 1'b0);
    @(negedge clk);
    chk1("t033_valid_held", ptw_if.resp_valid, 1'b1);
    chk1("t033_dc_rr_low2", dc_if.resp_ready, 1'b0);
    @(posedge clk); #1; ptw_if.resp_ready = 1'b1;
    @(negedge clk);
    chk1("t033_dc_rr_high", dc_if.resp_ready, 1'b1);
    chk1("t033_ptw_error", ptw_if.resp_error, 1'b1);
    chk32("t033_ptw_data", ptw_if.resp_data, 32'hCAFE_0001);
    @(posedge clk); #1; resp_err = 1'b0;
    repeat (2) @(posedge clk); #1;

    // both requesters continuously valid: four PTW wins then one LSU
    resp_word = 32'h0BAD_F00D;
    ptw_if.req_valid = 1'b1; ptw_if.req_addr = 32'h0000_5000; ptw_if.req_we = 1'b0; ptw_if.req_be = 4'hF;
    lsu_if.req_valid = 1'b1; lsu_if.req_addr = 32'h0000_6000; lsu_if.req_we = 1'b1;
    lsu_if.req_data = 32'h0000_0011; lsu_if.req_be = 4'h3;
    collect_grants(10, seq);
    chk32("t030_grant_order", {16'd0, seq}, 32'h0000_0210);
    @(posedge clk); #1;
    ptw_if.req_valid = 1'b0;
    lsu_if.req_valid = 1'b0;
    repeat (8) @(posedge clk); #1;

    // reset during WAIT_RESP after two PTW wins
    resp_delay = 6;
    ptw_if.req_valid = 1'b1;
    lsu_if.req_valid = 1'b1;
    collect_grants(2, seq);
    chk32("t034_pre_grants", {16'd0, seq}, 32'h0000_0000);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = dc_if.req_valid && dc_if.req_ready;
    end
    chk1("t034_issue_hs", got, 1'b1);
    @(posedge clk); #1; rst_n = 1'b0;
    @(negedge clk);
    chk32("t034_outputs_zero",
          {26'd0, ptw_if.req_ready, lsu_if.req_ready, dc_if.req_valid,
           dc_if.resp_ready, ptw_if.resp_valid, lsu_if.resp_valid}, 32'd0);
    @(posedge clk); #1;
    resp_delay = 0;
    rst_n = 1'b1;
    collect_grants(5, seq);
    chk32("t034_post_grants", {16'd0, seq}, 32'h0000_0010);
    @(posedge clk); #1;
    ptw_if.req_valid = 1'b0;
    lsu_if.req_valid = 1'b0;
    repeat (8) @(posedge clk);

    summary();
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dcache_port_arbiter.md
DCACHE_PORT_ARBITER -- requirements
Module: dcache_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: consecutive PTW grants while the LSU waits before the LSU is forced to win.
REQ-002 SHALL have clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have ptw_req_valid/ptw_req_we  input  1 each  page-table-walker request valid / write enable.
REQ-005 SHALL have ptw_req_addr/ptw_req_data  input  32 each; ptw_req_be  input  4.
REQ-006 SHALL have ptw_req_ready  output  1  PTW request accepted this cycle.
REQ-007 SHALL have lsu_req_valid/lsu_req_we  input  1 each; lsu_req_addr/lsu_req_data  input  32; lsu_req_be  input  4.
REQ-008 SHALL have lsu_req_ready  output  1  LSU request accepted this cycle.
REQ-009 SHALL have {ptw,lsu}_resp_valid  output  1; {ptw,lsu}_resp_data  output  32; {ptw,lsu}_resp_error  output  1; {ptw,lsu}_resp_ready  input  1.
REQ-010 SHALL have dcache_req_valid  output  1; dcache_req_addr/dcache_req_data  output  32; dcache_req_we  output  1; dcache_req_be  output  4; dcache_req_ready  input  1.
REQ-011 SHALL have dcache_resp_valid  input  1; dcache_resp_data  input  32; dcache_resp_error  input  1; dcache_resp_ready  output  1.
REQ-012 SHALL have flush_i  input  1  pipeline flush; discards LSU-owned results.

Function
REQ-013 SHALL implement states IDLE, ISSUE, WAIT_RESP; at most one cache transaction outstanding.
REQ-014 IDLE: if either valid, SHALL pick a winner, assert that requester's req_ready combinationally in the same cycle, latch its addr/data/we/be and owner bit, and go to ISSUE.
REQ-015 Winner SHALL be the PTW when both are valid, unless starve_cnt == STARVE_LIMIT; then the LSU wins.
REQ-016 starve_cnt (3-bit, saturating at STARVE_LIMIT) SHALL increment on each PTW grant while lsu_req_valid=1, and clear on any LSU grant.
REQ-017 ISSUE: dcache_req_valid=1 SHALL drive the latched fields unchanged; dcache_req_valid&&dcache_req_ready SHALL move to WAIT_RESP.
REQ-018 Cache request SHALL appear the cycle after acceptance; minimum accept-to-next-accept spacing SHALL be 3 cycles.
REQ-019 WAIT_RESP: dcache_resp_valid/data/error SHALL route combinationally to the owner's resp port; dcache_resp_ready SHALL equal the owner's resp_ready.
REQ-020 WAIT_RESP: dcache_resp_valid&&dcache_resp_ready SHALL return to IDLE; no new grant occurs in that cycle.
REQ-021 Non-owner resp_valid SHALL be 0 at all times; both req_ready SHALL be 0 outside IDLE.
REQ-022 flush_i SHALL set drop_flag when the owner is LSU in ISSUE/WAIT_RESP, or in the IDLE cycle that grants the LSU.
REQ-023 With drop_flag set, the transaction SHALL complete at the cache with dcache_resp_ready=1 and lsu_resp_valid=0; drop_flag SHALL clear on return to IDLE.
REQ-024 flush_i SHALL NOT affect PTW-owned transactions or starve_cnt.
REQ-025 flush_i in IDLE SHALL still permit grants; an LSU grant in that cycle SHALL be dropped per REQ-022.

Reset
REQ-026 Reset SHALL set state=IDLE, starve_cnt=0, drop_flag=0, owner=PTW, and latched fields=0.
REQ-027 During reset all outputs SHALL be 0.
REQ-028 Reset mid-transaction SHALL abandon it without emitting any response.

Verification
REQ-029 LSU alone, addr=0x1000, we=0; cache ready=1; resp 0xDEADBEEF after 2 cycles -> dcache_req_valid the cycle after accept; lsu_resp_data=0xDEADBEEF; ptw_resp_valid=0.
REQ-030 PTW and LSU valid continuously, STARVE_LIMIT=4 -> grant order PTW,PTW,PTW,PTW,LSU, repeating.
REQ-031 Store be=4'b0100, data=0x00AB0000, dcache_req_ready low 3 cycles -> fields held stable for all 4 ISSUE cycles; exactly one handshake.
REQ-032 flush_i pulse during LSU WAIT_RESP -> dcache_resp_ready=1, lsu_resp_valid stays 0, state IDLE after response.
REQ-033 PTW owner, dcache_resp_error=1, ptw_resp_ready low 2 cycles -> dcache_resp_ready low 2 cycles; ptw_resp_error=1 on handshake.
REQ-034 rst_n asserted in WAIT_RESP -> all outputs 0 immediately; first grant after release has starve_cnt=0.
